// File: rtl/cdma_tx_sequencer.sv
// cdma_tx_sequencer: frame controller for the cdma spreading core.
// Captures a payload and LFSR seed, holds the core in set/load so the Gold
// sequence restarts, then serialises the payload MSB-first, one bit per
// CHIPS_PER_BIT clocks. All outputs come straight from flops.
module cdma_tx_sequencer #(
    parameter int DATA_W        = 8,
    parameter int CHIPS_PER_BIT = 15,
    parameter int LOAD_CYCLES   = 1
) (
    input  logic                 clk_i,
    input  logic                 set_i,
    input  logic                 start_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [3:0]           seed_i,
    input  logic                 abort_i,
    output logic                 core_set_o,
    output logic [3:0]           core_seed_o,
    output logic                 signal_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] bit_idx_o,
    output logic [$clog2(CHIPS_PER_BIT)-1:0]               chip_cnt_o
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = $clog2(CHIPS_PER_BIT);
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_CHIP = CW'(CHIPS_PER_BIT - 1);
    localparam logic [LW-1:0] LAST_LOAD = LW'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    state_t            r_state, w_next;
    logic              r_core_set, w_core_set;
    logic [3:0]        r_seed,     w_seed;
    logic              r_sig,      w_sig;
    logic              r_busy,     w_busy;
    logic              r_done,     w_done;
    logic [BW-1:0]     r_bit,      w_bit;
    logic [CW-1:0]     r_chip,     w_chip;
    logic [LW-1:0]     r_load_cnt, w_load_cnt;
    // Payload shifts left as bits go out; the MSB is always the next bit.
    logic [DATA_W-1:0] r_data,     w_data;

    // State and registered outputs; set_i clears everything at once.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            r_state    <= S_IDLE;
            r_core_set <= 1'b0;
            r_seed     <= '0;
            r_sig      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bit      <= '0;
            r_chip     <= '0;
            r_load_cnt <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_next;
            r_core_set <= w_core_set;
            r_seed     <= w_seed;
            r_sig      <= w_sig;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_bit      <= w_bit;
            r_chip     <= w_chip;
            r_load_cnt <= w_load_cnt;
            r_data     <= w_data;
        end
    end

    // Next state; abort wins over the SEND-to-DONE move.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_LOAD;
            S_LOAD: begin
                if (abort_i)                      w_next = S_IDLE;
                else if (r_load_cnt == LAST_LOAD) w_next = S_SEND;
            end
            S_SEND: begin
                if (abort_i)                                          w_next = S_IDLE;
                else if (r_chip == LAST_CHIP && r_bit == LAST_BIT)    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not in a frame is zero.
    always_comb begin
        w_core_set = 1'b0;
        w_seed     = r_seed;
        w_sig      = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_bit      = '0;
        w_chip     = '0;
        w_load_cnt = '0;
        w_data     = r_data;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_data = data_i;
                    w_seed = seed_i;
                    w_busy = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_next == S_LOAD) begin
                    w_busy     = 1'b1;
                    w_load_cnt = r_load_cnt + LW'(1);
                end else if (w_next == S_SEND) begin
                    w_busy     = 1'b1;
                    w_core_set = 1'b1;
                    w_sig      = r_data[DATA_W-1];
                    w_data     = r_data << 1;
                end
            end
            S_SEND: begin
                if (w_next == S_SEND) begin
                    w_busy     = 1'b1;
                    w_core_set = 1'b1;
                    if (r_chip == LAST_CHIP) begin
                        w_bit  = r_bit + BW'(1);
                        w_sig  = r_data[DATA_W-1];
                        w_data = r_data << 1;
                    end else begin
                        w_bit  = r_bit;
                        w_chip = r_chip + CW'(1);
                        w_sig  = r_sig;
                    end
                end else if (w_next == S_DONE) begin
                    w_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign core_set_o  = r_core_set;
    assign core_seed_o = r_seed;
    assign signal_o    = r_sig;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign bit_idx_o   = r_bit;
    assign chip_cnt_o  = r_chip;
endmodule
